distribute_1xn_fifo_seq: RTL

DISTRIBUTE_1XN_FIFO_SEQ -- requirements
Module: distribute_1xn_fifo_seq

---
 rtl/distribute_1xn_fifo_seq_if.sv | 27 ++
 rtl/distribute_1xn_fifo_seq.sv | 52 +++++
 2 files changed

// File: rtl/distribute_1xn_fifo_seq_if.sv
// distribute_1xn_fifo_seq_if: handshake and data bundle between a producer, the 1xN switch and its N consumers
//   i_en, i_valid, i_data_bus, i_cmd -> input side (word, destination mask, enable)
//   o_ready                          <- input side accept indication
//   o_valid, o_data_bus, o_full      <- per-branch head valid, head word, full flag
//   i_ready                          -> per-branch consumer accept
interface distribute_1xn_fifo_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4
);
    logic                          i_en;
    logic                          i_valid;
    logic                          o_ready;
    logic [DATA_WIDTH-1:0]         i_data_bus;
    logic [NUM_OUT-1:0]            i_cmd;
    logic [NUM_OUT-1:0]            o_valid;
    logic [NUM_OUT-1:0]            i_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus;
    logic [NUM_OUT-1:0]            o_full;
    modport master (
        output i_en, i_valid, i_data_bus, i_cmd, i_ready,
        input  o_ready, o_valid, o_data_bus, o_full
    );
    modport slave (
        input  i_en, i_valid, i_data_bus, i_cmd, i_ready,
        output o_ready, o_valid, o_data_bus, o_full
    );
endinterface

// File: rtl/distribute_1xn_fifo_seq.sv
// distribute_1xn_fifo_seq: 1-to-N multicast switch with an independent FIFO per output branch
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears pointers and occupancy, not storage)
//   bus : slave side of distribute_1xn_fifo_seq_if (input handshake, destination mask, per-branch outputs)
module distribute_1xn_fifo_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    distribute_1xn_fifo_seq_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [NUM_OUT-1:0] w_full;
    logic [NUM_OUT-1:0] w_valid;
    logic [NUM_OUT-1:0] w_push;
    logic [NUM_OUT-1:0] w_pop;
    logic               w_accept;
    // Any targeted full branch blocks the whole word, so multicast is all-or-nothing;
    // occupancy is the registered value, so a same-cycle pop frees no space.
    assign bus.o_ready = bus.i_en & ~|(bus.i_cmd & w_full);
    assign w_accept    = bus.i_valid & bus.o_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_full  = w_full;
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_br
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0]         r_rd;
        logic [AW-1:0]         r_wr;
        logic [CW-1:0]         r_cnt;
        assign w_full[k]  = r_cnt == CW'(FIFO_DEPTH);
        assign w_valid[k] = r_cnt != '0;
        assign w_push[k]  = w_accept & bus.i_cmd[k];
        assign w_pop[k]   = w_valid[k] & bus.i_ready[k];
        assign bus.o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = w_valid[k] ? r_mem[r_rd] : '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[k]) r_wr <= r_wr + 1'b1;
                if (w_pop[k])  r_rd <= r_rd + 1'b1;
                r_cnt <= r_cnt + CW'(w_push[k]) - CW'(w_pop[k]);
            end
        end
        always_ff @(posedge clk) begin
            if (w_push[k]) r_mem[r_wr] <= bus.i_data_bus;
        end
    end
endmodule
